// File: rtl/uart_pkg.sv
// Shared UART types and timing helper used by uart_tx, uart_rx and uart_baud_tick.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    // Clocks per line bit; integer division truncates.
    function automatic int unsigned bit_cycles(input int unsigned clock_freq,
                                               input int unsigned baud);
        return clock_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Upstream word handshake plus serial line and status for the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Restartable per-bit cycle counter; the tick marks the last clock of each bit period.
module uart_baud_tick #(
    parameter int unsigned BIT_CYCLES = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic i_restart,
    output logic o_bit_tick_c
);
    localparam int unsigned CNT_W = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign o_bit_tick_c = (r_count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_restart || o_bit_tick_c) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned CLOCK_FREQ = 50000000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic        clock,
    input  logic        reset,
    uart_tx_if.slave    bus
);
    localparam int unsigned BIT_CYCLES = bit_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned BC_W       = $clog2(DATA_BITS + 1);
    localparam parity_t     PAR_MODE   = parity_t'(PARITY[1:0]);
    localparam logic [BC_W-1:0] LAST_DATA = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] LAST_STOP = BC_W'(STOP_BITS - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] w_shreg_next;
    logic [BC_W-1:0]      r_bit_cnt;
    logic [BC_W-1:0]      w_bit_cnt_next;
    logic                 r_parity;
    logic                 w_parity_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 w_restart;
    logic                 w_bit_tick;

    uart_baud_tick #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_baud (
        .clock        (clock),
        .reset        (reset),
        .i_restart    (w_restart),
        .o_bit_tick_c (w_bit_tick)
    );

    // Status is decoded from registers only, so no input reaches an output combinationally.
    assign bus.tx       = r_tx;
    assign bus.tx_ready = (r_state == S_IDLE);
    assign bus.tx_busy  = (r_state != S_IDLE);
    assign bus.tx_done  = (r_state == S_STOP) && w_bit_tick && (r_bit_cnt == LAST_STOP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shreg   <= w_shreg_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
        end
    end

    // The line value is computed for the next state so tx leaves the register already aligned.
    always_comb begin
        w_state_next   = r_state;
        w_shreg_next   = r_shreg;
        w_bit_cnt_next = r_bit_cnt;
        w_parity_next  = r_parity;
        w_tx_next      = r_tx;
        w_restart      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (bus.tx_valid) begin
                    w_shreg_next   = bus.tx_data;
                    w_parity_next  = (^bus.tx_data) ^ (PAR_MODE == PAR_ODD);
                    w_bit_cnt_next = '0;
                    w_restart      = 1'b1;
                    w_state_next   = S_START;
                    w_tx_next      = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_tick) begin
                    w_state_next   = S_DATA;
                    w_bit_cnt_next = '0;
                    w_tx_next      = r_shreg[0];
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    w_shreg_next = {1'b0, r_shreg[DATA_BITS-1:1]};
                    if (r_bit_cnt == LAST_DATA) begin
                        w_bit_cnt_next = '0;
                        if (PAR_MODE != PAR_NONE) begin
                            w_state_next = S_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = S_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BC_W'(1);
                        w_tx_next      = r_shreg[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_state_next   = S_STOP;
                    w_bit_cnt_next = '0;
                    w_tx_next      = 1'b1;
                end
            end
            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_tick) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        w_state_next   = S_IDLE;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BC_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end
endmodule
